shift_exec_pipe: RTL and testbench



---
 rtl/shift_pkg.sv | 26 ++
 rtl/shift_exec_pipe_if.sv | 30 +++
 rtl/rshifter.sv | 29 ++
 rtl/shift_exec_pipe.sv | 188 ++++++++++++++++++
 tb/tb_shift_exec_pipe.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift/rotate execute unit: datapath widths,
// opcode encodings and the 16-bit bit-reversal helper.
package shift_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  typedef logic [WIDTH-1:0] data_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Mirror a 16-bit word so that left shifts can reuse the right-shift core.
  function automatic data_t bitrev16(input data_t d);
    data_t r;
    for (int i = 0; i < 16; i++) begin
      r[i] = d[15-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_exec_pipe_if.sv
// Request/response bundle between decode, the shift unit and writeback.
//  in_*  : request from decode (valid/ready)
//  out_* : result to writeback (valid/ready)
// master = requester/consumer side, slave = the shift unit.
interface shift_exec_pipe_if;
  import shift_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  data_t      in_data;
  cnt_t       in_cnt;

  logic       out_valid;
  logic       out_ready;
  data_t      out_data;
  logic       out_zero;
  logic       out_err;

  modport master (
    output in_valid, in_op, in_data, in_cnt, out_ready,
    input  in_ready, out_valid, out_data, out_zero, out_err
  );

  modport slave (
    input  in_valid, in_op, in_data, in_cnt, out_ready,
    output in_ready, out_valid, out_data, out_zero, out_err
  );

endinterface

// File: rtl/rshifter.sv
// 16-bit logarithmic right shift/rotate core (four conditional stages of
// 1, 2, 4 and 8 positions). Purely combinational.
//  data_i : operand
//  cnt_i  : shift amount 0-15
//  rot_i  : 1 = rotate right, 0 = logical shift right
//  data_o : result
module rshifter
  import shift_pkg::*;
(
  input  data_t data_i,
  input  cnt_t  cnt_i,
  input  logic  rot_i,
  output data_t data_o
);

  data_t stg [CNT_W+1];

  assign stg[0] = data_i;

  for (genvar k = 0; k < CNT_W; k++) begin : g_stage
    localparam int unsigned SH = 1 << k;
    assign stg[k+1] = !cnt_i[k] ? stg[k] :
                      rot_i     ? ((stg[k] >> SH) | (stg[k] << (WIDTH - SH))) :
                                  (stg[k] >> SH);
  end

  assign data_o = stg[CNT_W];

endmodule

// File: rtl/shift_exec_pipe.sv
// Two-stage pipelined shift/rotate execute unit. Every op is mapped onto one
// right shift/rotate core: ROL uses the complemented count, SLL bit-reverses
// the operand before and the result after the core.
//  clk, rst_n : clock, asynchronous active-low reset
//  flush      : synchronous kill of both stages
//  bus        : request (in_*) and result (out_*) handshakes, slave side
// Build option: define SHIFT_SRA_EN to implement op 100 as arithmetic right
// shift; otherwise op 100 is treated as illegal.
module shift_exec_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  shift_exec_pipe_if.slave  bus
);
  import shift_pkg::*;

  // The core is hard-wired for a 16-bit datapath.
  if (WIDTH != shift_pkg::WIDTH || CNT_W != shift_pkg::CNT_W) begin : g_width_chk
    $error("shift_exec_pipe supports only WIDTH=16, CNT_W=4");
  end

  // S1 (decoded request) state
  logic  s1_valid_q, s1_valid_d;
  data_t s1_data_q,  s1_data_d;
  cnt_t  s1_cnt_q,   s1_cnt_d;
  logic  s1_rot_q,   s1_rot_d;
  logic  s1_rev_q,   s1_rev_d;
  logic  s1_err_q,   s1_err_d;
`ifdef SHIFT_SRA_EN
  logic  s1_sra_q,   s1_sra_d;
  logic  s1_sign_q,  s1_sign_d;
  logic  dec_sra_c;
`endif

  // S2 (result) state
  logic  out_valid_q, out_valid_d;
  data_t out_data_q,  out_data_d;
  logic  out_zero_q,  out_zero_d;
  logic  out_err_q,   out_err_d;

  logic  s2_ready_c, in_fire_c, s1_fire_c;
  data_t dec_data_c, shift_c, res_c;
  cnt_t  dec_cnt_c;
  logic  dec_rot_c, dec_rev_c, dec_err_c;

  assign s2_ready_c   = ~out_valid_q | bus.out_ready;
  assign bus.in_ready = ~s1_valid_q | s2_ready_c;
  assign in_fire_c    = bus.in_valid & bus.in_ready;
  assign s1_fire_c    = s1_valid_q & s2_ready_c;

  // Decode: map the opcode onto right-shift controls.
  always_comb begin
    dec_data_c = bus.in_data;
    dec_cnt_c  = bus.in_cnt;
    dec_rot_c  = 1'b0;
    dec_rev_c  = 1'b0;
    dec_err_c  = 1'b0;
`ifdef SHIFT_SRA_EN
    dec_sra_c  = 1'b0;
`endif
    case (bus.in_op)
      OP_ROL: begin
        dec_rot_c = 1'b1;
        dec_cnt_c = cnt_t'(5'd16 - {1'b0, bus.in_cnt});
      end
      OP_SLL: begin
        dec_data_c = bitrev16(bus.in_data);
        dec_rev_c  = 1'b1;
      end
      OP_ROR: dec_rot_c = 1'b1;
      OP_SRL: ;
`ifdef SHIFT_SRA_EN
      OP_SRA: dec_sra_c = 1'b1;
`endif
      default: begin
        // Zero count makes the core pass the operand through untouched.
        dec_err_c = 1'b1;
        dec_cnt_c = '0;
      end
    endcase
  end

  rshifter u_rshifter (
    .data_i (s1_data_q),
    .cnt_i  (s1_cnt_q),
    .rot_i  (s1_rot_q),
    .data_o (shift_c)
  );

  // Post-core fix-up: undo SLL reversal, then sign fill for SRA.
  always_comb begin
    res_c = s1_rev_q ? bitrev16(shift_c) : shift_c;
`ifdef SHIFT_SRA_EN
    if (s1_sra_q && s1_sign_q) begin
      res_c = res_c | ~(data_t'('1) >> s1_cnt_q);
    end
`endif
  end

  // Next-state for both stages; flush overrides every load.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_cnt_d    = s1_cnt_q;
    s1_rot_d    = s1_rot_q;
    s1_rev_d    = s1_rev_q;
    s1_err_d    = s1_err_q;
`ifdef SHIFT_SRA_EN
    s1_sra_d    = s1_sra_q;
    s1_sign_d   = s1_sign_q;
`endif
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_zero_d  = out_zero_q;
    out_err_d   = out_err_q;

    if (s1_fire_c) s1_valid_d = 1'b0;
    if (in_fire_c) begin
      s1_valid_d = 1'b1;
      s1_data_d  = dec_data_c;
      s1_cnt_d   = dec_cnt_c;
      s1_rot_d   = dec_rot_c;
      s1_rev_d   = dec_rev_c;
      s1_err_d   = dec_err_c;
`ifdef SHIFT_SRA_EN
      s1_sra_d   = dec_sra_c;
      s1_sign_d  = bus.in_data[15];
`endif
    end

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
    if (s1_fire_c) begin
      out_valid_d = 1'b1;
      out_data_d  = res_c;
      out_zero_d  = (res_c == '0);
      out_err_d   = s1_err_q;
    end

    if (flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_cnt_q    <= '0;
      s1_rot_q    <= 1'b0;
      s1_rev_q    <= 1'b0;
      s1_err_q    <= 1'b0;
`ifdef SHIFT_SRA_EN
      s1_sra_q    <= 1'b0;
      s1_sign_q   <= 1'b0;
`endif
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_cnt_q    <= s1_cnt_d;
      s1_rot_q    <= s1_rot_d;
      s1_rev_q    <= s1_rev_d;
      s1_err_q    <= s1_err_d;
`ifdef SHIFT_SRA_EN
      s1_sra_q    <= s1_sra_d;
      s1_sign_q   <= s1_sign_d;
`endif
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_zero  = out_zero_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_shift_exec_pipe.sv
// Directed and randomised checks of shift_exec_pipe against hand-computed
// values and an independent behavioural shift model.
module tb_shift_exec_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  shift_exec_pipe_if bus ();

  shift_exec_pipe #(.WIDTH(16), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [16:0] expq [$];
  logic [16:0] e;
  int          idx, got, sent, recv;
  logic        stall_prev;
  logic [15:0] held;

  logic [2:0]  bp_op   [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd0, 3'd3, 3'd1};
  logic [15:0] bp_data [8] = '{16'h8001, 16'h00FF, 16'h0001, 16'hF000,
                               16'hBEEF, 16'h1234, 16'hFFFF, 16'h0F0F};
  logic [3:0]  bp_cnt  [8] = '{4'd1, 4'd4, 4'd1, 4'd12, 4'd3, 4'd8, 4'd15, 4'd2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: left ops computed directly, not via reversal.
  function automatic logic [16:0] ref_model(input logic [2:0] op, input logic [15:0] d,
                                            input logic [3:0] c);
    logic [15:0] r;
    logic        er;
    er = 1'b0;
    case (op)
      3'd0:    r = (c == 4'd0) ? d : ((d << c) | (d >> (16 - int'(c))));
      3'd1:    r = d << c;
      3'd2:    r = (c == 4'd0) ? d : ((d >> c) | (d << (16 - int'(c))));
      3'd3:    r = d >> c;
`ifdef SHIFT_SRA_EN
      3'd4:    r = $unsigned($signed(d) >>> c);
`endif
      default: begin r = d; er = 1'b1; end
    endcase
    return {er, r};
  endfunction

  task automatic do_op(input string tag, input logic [2:0] op, input logic [15:0] d,
                       input logic [3:0] c, input logic [15:0] ed, input logic ez,
                       input logic ee);
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_data   = d;
    bus.in_cnt    = c;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #1;
    check({tag, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #2;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_data"},  32'(bus.out_data),  32'(ed));
    check({tag, "_zero"},  32'(bus.out_zero),  32'(ez));
    check({tag, "_err"},   32'(bus.out_err),   32'(ee));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 3'd0;
    bus.in_data   = 16'h0000;
    bus.in_cnt    = 4'd0;
    bus.out_ready = 1'b1;

    // Reset state
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_out_zero",  32'(bus.out_zero),  32'd0);
    check("rst_out_err",   32'(bus.out_err),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single ops
    do_op("rol",      3'd0, 16'h8001, 4'd1,  16'h0003, 1'b0, 1'b0);
    do_op("sll",      3'd1, 16'h00FF, 4'd4,  16'h0FF0, 1'b0, 1'b0);
    do_op("ror",      3'd2, 16'h0001, 4'd1,  16'h8000, 1'b0, 1'b0);
    do_op("srl",      3'd3, 16'h8000, 4'd15, 16'h0001, 1'b0, 1'b0);
    do_op("sll_zero", 3'd1, 16'h8000, 4'd1,  16'h0000, 1'b1, 1'b0);
`ifdef SHIFT_SRA_EN
    do_op("sra",      3'd4, 16'h8000, 4'd3,  16'hF000, 1'b0, 1'b0);
`else
    do_op("sra_off",  3'd4, 16'h8000, 4'd3,  16'h8000, 1'b0, 1'b1);
`endif
    do_op("ill7",     3'd7, 16'h1234, 4'd5,  16'h1234, 1'b0, 1'b1);
    do_op("ill5_zero",3'd5, 16'h0000, 4'd3,  16'h0000, 1'b1, 1'b1);
    do_op("rol_c0",   3'd0, 16'hA5C3, 4'd0,  16'hA5C3, 1'b0, 1'b0);
    do_op("ror_c0",   3'd2, 16'h5A3C, 4'd0,  16'h5A3C, 1'b0, 1'b0);
    do_op("rol_c15",  3'd0, 16'h0001, 4'd15, 16'h8000, 1'b0, 1'b0);

    // Backpressure: 8 back-to-back ops, consumer stalled for 5 cycles
    @(posedge clk); #1;
    idx = 0; got = 0; stall_prev = 1'b0; held = 16'h0;
    expq.delete();
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      if (cyc != 0) begin @(posedge clk); #1; end
      bus.out_ready = (cyc >= 5);
      bus.in_valid  = (idx < 8);
      if (idx < 8) begin
        bus.in_op   = bp_op[idx];
        bus.in_data = bp_data[idx];
        bus.in_cnt  = bp_cnt[idx];
      end
      #1;
      if (cyc == 4) begin
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_accepts",      32'(idx),          32'd2);
      end
      if (stall_prev) check("bp_stable", 32'(bus.out_data), 32'(held));
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          check("bp_spurious_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = expq.pop_front();
          check("bp_data", 32'(bus.out_data), 32'(e[15:0]));
          check("bp_err",  32'(bus.out_err),  32'(e[16]));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(ref_model(bus.in_op, bus.in_data, bus.in_cnt));
        idx++;
      end
    end
    bus.in_valid = 1'b0;
    check("bp_count", 32'(got), 32'd8);
    @(posedge clk); #2;
    check("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // Flush with both stages full and a request on offer
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_op = 3'd3; bus.in_data = 16'h0F00; bus.in_cnt = 4'd4;
    @(posedge clk); #1;
    bus.in_op = 3'd2; bus.in_data = 16'h0011; bus.in_cnt = 4'd1;
    @(posedge clk); #1;
    bus.in_op = 3'd1; bus.in_data = 16'h0003; bus.in_cnt = 4'd2;
    flush = 1'b1;
    #1;
    check("fl_full_valid",   32'(bus.out_valid), 32'd1);
    check("fl_full_inready", 32'(bus.in_ready),  32'd0);
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("fl_out_valid", 32'(bus.out_valid), 32'd0);
    check("fl_s1_empty",  32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #2;
    check("fl_drained", 32'(bus.out_valid), 32'd0);

    // Flush during an accepted transfer discards it
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_op = 3'd0; bus.in_data = 16'h00F0; bus.in_cnt = 4'd4;
    flush = 1'b1;
    #1;
    check("fl_xfer_inready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #2;
    check("fl_xfer_dropped", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #2;
    check("fl_xfer_dropped2", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-stream
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_op = 3'd2; bus.in_data = 16'h00F1; bus.in_cnt = 4'd4;
    @(posedge clk); #1;
    bus.in_op = 3'd7; bus.in_data = 16'h4321;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #1;
    check("rs_pre_valid", 32'(bus.out_valid), 32'd1);
    check("rs_pre_data",  32'(bus.out_data),  32'h100F);
    #2 rst_n = 1'b0;
    #1;
    check("rs_out_valid", 32'(bus.out_valid), 32'd0);
    check("rs_out_data",  32'(bus.out_data),  32'h0);
    check("rs_out_err",   32'(bus.out_err),   32'd0);
    check("rs_in_ready",  32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("rs_after", 3'd0, 16'h1234, 4'd4, 16'h2341, 1'b0, 1'b0);

    // Random stream against the reference model
    @(posedge clk); #1;
    sent = 0; recv = 0;
    expq.delete();
    for (int cyc = 0; cyc < 60000 && recv < 10000; cyc++) begin
      if (cyc != 0) begin @(posedge clk); #1; end
      bus.in_valid  = (sent < 10000) && ($urandom_range(0, 3) != 0);
      bus.in_op     = 3'($urandom_range(0, 7));
      bus.in_data   = 16'($urandom);
      bus.in_cnt    = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          check("rnd_spurious_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          e = expq.pop_front();
          check("rnd_data", 32'(bus.out_data), 32'(e[15:0]));
          check("rnd_zero", 32'(bus.out_zero), 32'(e[15:0] == 16'h0));
          check("rnd_err",  32'(bus.out_err),  32'(e[16]));
        end
        recv++;
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(ref_model(bus.in_op, bus.in_data, bus.in_cnt));
        sent++;
      end
    end
    bus.in_valid = 1'b0;
    check("rnd_count", 32'(recv), 32'd10000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
